// File: rtl/booth_mult_sequencer_if.sv
// booth_mult_sequencer_if: operand stream, multiplier link and result stream
// of the Booth multiplier sequencer bundled into one interface.
// The master modport is the sequencer's view and the slave modport is the
// surrounding environment (producer, multiplier and consumer).
// Optional accumulator signals are present when MULT_SEQ_ACC_EN is defined.
`timescale 1ns/1ps

interface booth_mult_sequencer_if #(
    parameter int FIFO_DEPTH = 4
) ();
    logic                          In_Valid;
    logic                          In_Ready;
    logic [7:0]                    In_A;
    logic [7:0]                    In_B;
    logic                          Mult_Start_Sig;
    logic [7:0]                    Mult_A;
    logic [7:0]                    Mult_B;
    logic                          Mult_Done_Sig;
    logic [15:0]                   Mult_Product;
    logic                          Out_Valid;
    logic                          Out_Ready;
    logic [15:0]                   Out_Product;
    logic                          Timeout_Err;
    logic [$clog2(FIFO_DEPTH):0]   Fifo_Count;
`ifdef MULT_SEQ_ACC_EN
    logic                          Acc_Clr;
    logic [23:0]                   Acc_Sum;

    modport master (
        input  In_Valid, In_A, In_B, Mult_Done_Sig, Mult_Product, Out_Ready, Acc_Clr,
        output In_Ready, Mult_Start_Sig, Mult_A, Mult_B, Out_Valid, Out_Product,
               Timeout_Err, Fifo_Count, Acc_Sum
    );

    modport slave (
        output In_Valid, In_A, In_B, Mult_Done_Sig, Mult_Product, Out_Ready, Acc_Clr,
        input  In_Ready, Mult_Start_Sig, Mult_A, Mult_B, Out_Valid, Out_Product,
               Timeout_Err, Fifo_Count, Acc_Sum
    );
`else
    modport master (
        input  In_Valid, In_A, In_B, Mult_Done_Sig, Mult_Product, Out_Ready,
        output In_Ready, Mult_Start_Sig, Mult_A, Mult_B, Out_Valid, Out_Product,
               Timeout_Err, Fifo_Count
    );

    modport slave (
        output In_Valid, In_A, In_B, Mult_Done_Sig, Mult_Product, Out_Ready,
        input  In_Ready, Mult_Start_Sig, Mult_A, Mult_B, Out_Valid, Out_Product,
               Timeout_Err, Fifo_Count
    );
`endif
endinterface

// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer: buffers signed 8-bit operand pairs in a FIFO, feeds
// them to a radix-4 Booth multiplier using its Start/A/B hold-high protocol,
// captures the product on Done and offers it on a valid/ready stream.
// A watchdog drops an operation whose Done never arrives and raises a sticky
// Timeout_Err.
// Optional feature macro: MULT_SEQ_ACC_EN adds a 24-bit wrapping accumulator
// of captured products (Acc_Clr / Acc_Sum).
`timescale 1ns/1ps

module booth_mult_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    booth_mult_sequencer_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        fifo_mem_q [FIFO_DEPTH];
    logic [15:0]        fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               start_q, start_d;
    logic [7:0]         mult_a_q, mult_a_d;
    logic [7:0]         mult_b_q, mult_b_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               out_valid_q, out_valid_d;
    logic [15:0]        out_product_q, out_product_d;
    logic               timeout_err_q, timeout_err_d;
`ifdef MULT_SEQ_ACC_EN
    logic [23:0]        acc_sum_q, acc_sum_d;
`endif

    logic               in_ready;
    logic               push;
    logic               pop;
    logic               capture;
    logic [15:0]        head;

    assign in_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push     = bus.In_Valid && in_ready;
    assign head     = fifo_mem_q[rd_ptr_q];

    // Next-state logic for the FIFO, the sequencing FSM, the output register and the accumulator
    always_comb begin
        state_d       = state_q;
        fifo_mem_d    = fifo_mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        start_d       = start_q;
        mult_a_d      = mult_a_q;
        mult_b_d      = mult_b_q;
        wd_d          = wd_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        timeout_err_d = timeout_err_q;
        pop           = 1'b0;
        capture       = 1'b0;

        if (out_valid_q && bus.Out_Ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                start_d = 1'b0;
                if ((count_q != '0) && (!out_valid_q || bus.Out_Ready)) begin
                    pop      = 1'b1;
                    mult_a_d = head[15:8];
                    mult_b_d = head[7:0];
                    start_d  = 1'b1;
                    wd_d     = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                wd_d = wd_q + WD_W'(1);
                if (bus.Mult_Done_Sig) begin
                    capture       = 1'b1;
                    out_product_d = bus.Mult_Product;
                    out_valid_d   = 1'b1;
                    start_d       = 1'b0;
                    state_d       = GAP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    start_d       = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = GAP;
                end
            end
            GAP: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (push) begin
            fifo_mem_d[wr_ptr_q] = {bus.In_A, bus.In_B};
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

`ifdef MULT_SEQ_ACC_EN
        acc_sum_d = acc_sum_q;
        if (bus.Acc_Clr) begin
            acc_sum_d = capture ? {{8{bus.Mult_Product[15]}}, bus.Mult_Product} : 24'd0;
        end else if (capture) begin
            acc_sum_d = acc_sum_q + {{8{bus.Mult_Product[15]}}, bus.Mult_Product};
        end
`endif
    end

    // Register all state with a synchronous active-low reset; FIFO storage is left as-is on reset
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            start_q       <= 1'b0;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            wd_q          <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            timeout_err_q <= 1'b0;
`ifdef MULT_SEQ_ACC_EN
            acc_sum_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            fifo_mem_q    <= fifo_mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            start_q       <= start_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            wd_q          <= wd_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            timeout_err_q <= timeout_err_d;
`ifdef MULT_SEQ_ACC_EN
            acc_sum_q     <= acc_sum_d;
`endif
        end
    end

    assign bus.In_Ready       = in_ready;
    assign bus.Mult_Start_Sig = start_q;
    assign bus.Mult_A         = mult_a_q;
    assign bus.Mult_B         = mult_b_q;
    assign bus.Out_Valid      = out_valid_q;
    assign bus.Out_Product    = out_product_q;
    assign bus.Timeout_Err    = timeout_err_q;
    assign bus.Fifo_Count     = count_q;
`ifdef MULT_SEQ_ACC_EN
    assign bus.Acc_Sum        = acc_sum_q;
`endif

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// tb_booth_mult_sequencer: drives operand pairs into booth_mult_sequencer,
// stands in for the Booth multiplier with a behavioural stub (Done in the
// 7th Start-high cycle, optionally never), and checks results through a
// scoreboard queue filled at push time.
`timescale 1ns/1ps

module tb_booth_mult_sequencer;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 15;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    booth_mult_sequencer_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    booth_mult_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb [$];
    logic        done_en = 1'b1;
    int          mult_cnt = 0;

    // Multiplier stub: counts Start-high cycles and raises Done in the 7th one
    always @(posedge CLK) begin
        if (bus.Mult_Start_Sig !== 1'b1) mult_cnt <= 0;
        else                              mult_cnt <= mult_cnt + 1;
    end

    assign bus.Mult_Done_Sig = done_en && (bus.Mult_Start_Sig === 1'b1) && (mult_cnt == 6);
    assign bus.Mult_Product  = $signed({{8{bus.Mult_A[7]}}, bus.Mult_A}) *
                               $signed({{8{bus.Mult_B[7]}}, bus.Mult_B});

    // Scoreboard: every accepted result transfer is compared with the oldest expectation
    always @(negedge CLK) begin
        logic [15:0] exp_p;
        if (RSTn && bus.Out_Valid === 1'b1 && bus.Out_Ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_result: got %h, no result expected", bus.Out_Product);
            end else begin
                exp_p = sb.pop_front();
                if (bus.Out_Product !== exp_p) begin
                    errors++;
                    $display("[TB] FAIL product: got %h, expected %h", bus.Out_Product, exp_p);
                end
            end
        end
    end

    function automatic logic [15:0] model_product(input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sbv;
        int p;
        sa  = a[7] ? int'(a) - 256 : int'(a);
        sbv = b[7] ? int'(b) - 256 : int'(b);
        p   = sa * sbv;
        return p[15:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one pair and hold it until accepted; queue its expected result if it will produce one
    task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                             input bit has_result, input logic [15:0] expected);
        int waited = 0;
        bit ok = 0;
        bus.In_A     = a;
        bus.In_B     = b;
        bus.In_Valid = 1'b1;
        while (!ok && waited < 100) begin
            @(negedge CLK);
            if (bus.In_Ready === 1'b1) ok = 1;
            else begin
                tick();
                waited++;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL push_accept: In_Ready stayed %b, expected 1", bus.In_Ready);
            bus.In_Valid = 1'b0;
        end else begin
            if (has_result) sb.push_back(expected);
            tick();
            bus.In_Valid = 1'b0;
        end
    endtask

    // Wait until every queued operation has been run and its result consumed
    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || bus.Fifo_Count !== '0 || bus.Mult_Start_Sig !== 1'b0 ||
                bus.Out_Valid !== 1'b0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL drain: %0d results still pending after %0d cycles, expected 0", sb.size(), budget);
        end
        tick();
    endtask

    task automatic test_reset();
        bus.In_Valid  = 1'b0;
        bus.In_A      = '0;
        bus.In_B      = '0;
        bus.Out_Ready = 1'b0;
`ifdef MULT_SEQ_ACC_EN
        bus.Acc_Clr   = 1'b0;
`endif
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.In_Ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.In_Ready); end
        checks++;
        if (bus.Mult_Start_Sig !== 1'b0 || bus.Mult_A !== 8'h00 || bus.Mult_B !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_mult: start %b a %h b %h, expected 0 00 00", bus.Mult_Start_Sig, bus.Mult_A, bus.Mult_B);
        end
        checks++;
        if (bus.Out_Valid !== 1'b0 || bus.Out_Product !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_out: valid %b product %h, expected 0 0000", bus.Out_Valid, bus.Out_Product);
        end
        checks++;
        if (bus.Timeout_Err !== 1'b0 || bus.Fifo_Count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_status: err %b count %0d, expected 0 0", bus.Timeout_Err, bus.Fifo_Count);
        end
`ifdef MULT_SEQ_ACC_EN
        checks++;
        if (bus.Acc_Sum !== 24'h000000) begin errors++; $display("[TB] FAIL reset_acc: got %h, expected 000000", bus.Acc_Sum); end
`endif
        tick();
        RSTn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int start_high = 0;
        int first_valid = -1;
        bus.Out_Ready = 1'b1;
        push_pair(8'd3, 8'd5, 1, 16'h000F);
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (bus.Mult_Start_Sig === 1'b1) start_high++;
            if (bus.Out_Valid === 1'b1 && first_valid < 0) first_valid = k;
        end
        checks++;
        if (start_high != 7) begin errors++; $display("[TB] FAIL start_length: got %0d cycles, expected 7", start_high); end
        checks++;
        if (first_valid != 8) begin errors++; $display("[TB] FAIL latency: got %0d edges, expected 8", first_valid); end
        tick();
        wait_drain(50);
    endtask

    task automatic test_signed();
        bus.Out_Ready = 1'b1;
        push_pair(8'hFD, 8'h07, 1, 16'hFFEB);
        push_pair(8'h80, 8'h80, 1, 16'h4000);
        wait_drain(100);
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        bit sixth_ready = 1'b1;
        int n = 0;
        bit bad_prod = 0, bad_start = 0, bad_count = 0, bad_ready = 0;
        logic [7:0] a, b;
        logic [15:0] held;
        bus.Out_Ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = 8'(i * 17 - 40);
            b = 8'(7 - 3 * i);
            bus.In_A     = a;
            bus.In_B     = b;
            bus.In_Valid = 1'b1;
            @(negedge CLK);
            if (bus.In_Ready === 1'b1) begin
                accepted++;
                sb.push_back(model_product(a, b));
            end else if (i == 5) begin
                sixth_ready = 1'b0;
            end
            tick();
        end
        bus.In_Valid = 1'b0;
        checks++;
        if (accepted != 5) begin errors++; $display("[TB] FAIL accepted_count: got %0d, expected 5", accepted); end
        checks++;
        if (sixth_ready !== 1'b0) begin errors++; $display("[TB] FAIL sixth_in_ready: got %b, expected 0", sixth_ready); end

        while (bus.Out_Valid !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (bus.Out_Valid !== 1'b1) begin errors++; $display("[TB] FAIL first_result: Out_Valid %b, expected 1", bus.Out_Valid); end

        held = (sb.size() > 0) ? sb[0] : 16'hxxxx;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.Out_Product !== held || bus.Out_Valid !== 1'b1) bad_prod = 1;
            if (bus.Mult_Start_Sig !== 1'b0) bad_start = 1;
            if (bus.Fifo_Count !== 3'd4) bad_count = 1;
            if (bus.In_Ready !== 1'b0) bad_ready = 1;
        end
        checks++;
        if (bad_prod) begin errors++; $display("[TB] FAIL hold_product: got %h valid %b, expected %h valid 1", bus.Out_Product, bus.Out_Valid, held); end
        checks++;
        if (bad_start) begin errors++; $display("[TB] FAIL hold_start: got %b during backpressure, expected 0", bus.Mult_Start_Sig); end
        checks++;
        if (bad_count) begin errors++; $display("[TB] FAIL hold_count: got %0d, expected 4", bus.Fifo_Count); end
        checks++;
        if (bad_ready) begin errors++; $display("[TB] FAIL hold_in_ready: got %b, expected 0", bus.In_Ready); end

        tick();
        bus.Out_Ready = 1'b1;
        a = 8'(5 * 17 - 40);
        b = 8'(7 - 3 * 5);
        push_pair(a, b, 1, model_product(a, b));
        wait_drain(300);
    endtask

    task automatic test_timeout();
        int start_high = 0;
        bit seen = 0;
        bit bad_valid = 0;
        bus.Out_Ready = 1'b1;
        done_en = 1'b0;
        push_pair(8'h11, 8'h22, 0, 16'h0000);
        push_pair(8'hF0, 8'h09, 1, model_product(8'hF0, 8'h09));
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (bus.Out_Valid !== 1'b0) bad_valid = 1;
            if (bus.Mult_Start_Sig === 1'b1) begin
                start_high++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        checks++;
        if (start_high != TIMEOUT) begin errors++; $display("[TB] FAIL timeout_length: got %0d cycles, expected %0d", start_high, TIMEOUT); end
        checks++;
        if (bus.Timeout_Err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b, expected 1", bus.Timeout_Err); end
        checks++;
        if (bad_valid) begin errors++; $display("[TB] FAIL timeout_no_result: Out_Valid rose, expected 0"); end
        done_en = 1'b1;
        wait_drain(100);
        checks++;
        if (bus.Timeout_Err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b, expected 1", bus.Timeout_Err); end
    endtask

    task automatic test_reset_mid_run();
        bus.Out_Ready = 1'b1;
        done_en = 1'b1;
        push_pair(8'h12, 8'h03, 1, model_product(8'h12, 8'h03));
        push_pair(8'h21, 8'h04, 1, model_product(8'h21, 8'h04));
        push_pair(8'h30, 8'h05, 1, model_product(8'h30, 8'h05));
        push_pair(8'h44, 8'h06, 1, model_product(8'h44, 8'h06));
        @(negedge CLK);
        checks++;
        if (bus.Mult_Start_Sig !== 1'b1 || bus.Fifo_Count !== 3'd3) begin
            errors++;
            $display("[TB] FAIL pre_reset: start %b count %0d, expected 1 3", bus.Mult_Start_Sig, bus.Fifo_Count);
        end
        RSTn = 1'b0;
        sb.delete();
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.Mult_Start_Sig !== 1'b0 || bus.Fifo_Count !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_fsm: start %b count %0d, expected 0 0", bus.Mult_Start_Sig, bus.Fifo_Count);
        end
        checks++;
        if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1 || bus.Timeout_Err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_status: valid %b ready %b err %b, expected 0 1 0", bus.Out_Valid, bus.In_Ready, bus.Timeout_Err);
        end
        tick();
        RSTn = 1'b1;
        tick();
        push_pair(8'h02, 8'h03, 1, 16'h0006);
        wait_drain(50);
    endtask

`ifdef MULT_SEQ_ACC_EN
    task automatic test_accumulator();
        int n = 0;
        bus.Out_Ready = 1'b1;
        bus.Acc_Clr   = 1'b0;
        push_pair(8'd3, 8'd4, 1, 16'h000C);
        push_pair(8'hFE, 8'd5, 1, 16'hFFF6);
        wait_drain(100);
        checks++;
        if (bus.Acc_Sum !== 24'h000002) begin errors++; $display("[TB] FAIL acc_sum: got %h, expected 000002", bus.Acc_Sum); end

        push_pair(8'd5, 8'd5, 1, 16'h0019);
        while (bus.Mult_Done_Sig !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        bus.Acc_Clr = 1'b1;
        tick();
        bus.Acc_Clr = 1'b0;
        wait_drain(50);
        checks++;
        if (bus.Acc_Sum !== 24'h000019) begin errors++; $display("[TB] FAIL acc_clr_capture: got %h, expected 000019", bus.Acc_Sum); end

        bus.Acc_Clr = 1'b1;
        tick();
        bus.Acc_Clr = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.Acc_Sum !== 24'h000000) begin errors++; $display("[TB] FAIL acc_clr: got %h, expected 000000", bus.Acc_Sum); end
        tick();

        push_pair(8'hFF, 8'h01, 1, 16'hFFFF);
        wait_drain(50);
        checks++;
        if (bus.Acc_Sum !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL acc_sign_extend: got %h, expected FFFFFF", bus.Acc_Sum); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
`ifdef MULT_SEQ_ACC_EN
        test_accumulator();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: %0d results never produced, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
